// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a FIFO read port (1-cycle read latency) into a
// valid/ready stream with fixed-length packet framing and a 2-entry skid buffer.
//
// Ports:
//   rd_clk      sole clock, shared with the FIFO read side
//   reset       asynchronous, active-high reset
//   en          permits issuing new FIFO reads
//   fifo_empty  FIFO empty flag
//   fifo_rd_en  FIFO read enable (combinational)
//   fifo_dout   FIFO data, valid the cycle after fifo_rd_en
//   m_valid     stream word available
//   m_ready     downstream accepts the word
//   m_data      stream word (skid buffer head)
//   m_last      final word of the current packet
//   pkt_count   completed packets, wraps modulo 2^16
//   busy        a word is in flight or buffered
module fifo_stream_reader #(
    parameter int bitw    = 16,
    parameter int pkt_len = 4
) (
    input  logic            rd_clk,
    input  logic            reset,
    input  logic            en,
    input  logic            fifo_empty,
    output logic            fifo_rd_en,
    input  logic [bitw-1:0] fifo_dout,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [bitw-1:0] m_data,
    output logic            m_last,
    output logic [15:0]     pkt_count,
    output logic            busy
);

    localparam logic [15:0] LAST_IDX = 16'(pkt_len - 1);

    logic            inflight_q, inflight_d;
    logic [1:0]      occ_q, occ_d;
    logic [bitw-1:0] head_q, head_d;
    logic [bitw-1:0] tail_q, tail_d;
    logic [15:0]     word_idx_q, word_idx_d;
    logic [15:0]     pkt_count_q, pkt_count_d;

    logic            pop;
    logic            at_last;
    logic [2:0]      outstanding;

    assign m_valid = (occ_q != 2'd0);
    assign pop     = m_valid & m_ready;
    assign at_last = (word_idx_q == LAST_IDX);

    // Words that will still occupy the buffer after this edge; a new read
    // is only safe if its data will find a free slot when it lands.
    assign outstanding = {1'b0, occ_q}
                       + {2'b00, inflight_q}
                       - {2'b00, pop};

    assign fifo_rd_en = !reset & en & !fifo_empty
                      & (outstanding < 3'd2);

    assign m_data    = head_q;
    assign m_last    = m_valid & at_last;
    assign pkt_count = pkt_count_q;
    assign busy      = inflight_q | (occ_q != 2'd0);

    always_comb begin
        inflight_d  = fifo_rd_en;
        occ_d       = occ_q;
        head_d      = head_q;
        tail_d      = tail_q;
        word_idx_d  = word_idx_q;
        pkt_count_d = pkt_count_q;

        case ({inflight_q, pop})
            2'b10: begin
                if (occ_q == 2'd0) begin
                    head_d = fifo_dout;
                end else begin
                    tail_d = fifo_dout;
                end
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                head_d = tail_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                // Capture and pop together: occupancy is unchanged, the
                // tail (if any) moves up and the new word lands behind it.
                if (occ_q == 2'd2) begin
                    head_d = tail_q;
                    tail_d = fifo_dout;
                end else begin
                    head_d = fifo_dout;
                end
            end
            default: begin
            end
        endcase

        if (pop) begin
            if (at_last) begin
                word_idx_d  = 16'd0;
                pkt_count_d = pkt_count_q + 16'd1;
            end else begin
                word_idx_d = word_idx_q + 16'd1;
            end
        end
    end

    always_ff @(posedge rd_clk or posedge reset) begin
        if (reset) begin
            inflight_q  <= 1'b0;
            occ_q       <= 2'd0;
            head_q      <= '0;
            tail_q      <= '0;
            word_idx_q  <= 16'd0;
            pkt_count_q <= 16'd0;
        end else begin
            inflight_q  <= inflight_d;
            occ_q       <= occ_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            word_idx_q  <= word_idx_d;
            pkt_count_q <= pkt_count_d;
        end
    end

    // A capture into a full buffer without a pop would need a third slot.
    a_no_overflow : assert property (
        @(posedge rd_clk) disable iff (reset)
        !(inflight_q && !pop && occ_q == 2'd2) && (occ_q != 2'd3)
    );

endmodule
